// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg -- shared CPU front-end definitions: FSM states, vectors, next-PC select codes.
// Rev 1.0
`default_nettype none

package pc_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STALL_MD  = 2'd1,
    ST_EXC_FLUSH = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_JMP  = 3'd2,
    NPC_HOLD = 3'd3,
    NPC_EPC  = 3'd4,
    NPC_EXC  = 3'd5
  } npc_sel_e;

  localparam logic [31:0] EXC_VEC_DEF  = 32'h0040_0004;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_seq_ctrl_npc_mux.sv
// npc_mux -- priority next-PC selector: exc > eret > hold > jmp > br > pc+4.
// Rev 1.0
`default_nettype none

module npc_mux
  import pc_seq_ctrl_pkg::*;
(
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        hold_i,
  input  logic        jmp_i,
  input  logic        br_i,
  input  logic [31:0] pc_cur_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] jmp_target_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] exc_vec_i,
  output logic [31:0] npc_o
);

  npc_sel_e sel;

  always_comb begin
    if (exc_i)       sel = NPC_EXC;
    else if (eret_i) sel = NPC_EPC;
    else if (hold_i) sel = NPC_HOLD;
    else if (jmp_i)  sel = NPC_JMP;
    else if (br_i)   sel = NPC_BR;
    else             sel = NPC_SEQ;
  end

  always_comb begin
    npc_o = pc_plus4(pc_cur_i);
    case (sel)
      NPC_EXC:  npc_o = exc_vec_i;
      NPC_EPC:  npc_o = epc_i;
      NPC_HOLD: npc_o = pc_cur_i;
      NPC_JMP:  npc_o = jmp_target_i;
      NPC_BR:   npc_o = br_target_i;
      default:  npc_o = pc_plus4(pc_cur_i);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl -- PC sequencing, hazard stall and redirect control.
// Exception/ERET path and EXC_FLUSH state compiled in by PC_SEQ_CTRL_EXC_EN. Rev 1.0
`default_nettype none

module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 63,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        ld_use,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        pc_ena,
  output logic        pc_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        md_timeout,
  output logic [1:0]  state
);

  localparam logic [5:0] MD_LIMIT = MD_TIMEOUT[5:0];

  logic [1:0]  state_q;
  logic [5:0]  md_cnt_q;
  logic        md_timeout_q;
  logic        in_run;
  logic        in_md;
  logic        in_flush;
  logic        exc_v;
  logic        eret_v;
  logic [31:0] mux_npc;

  assign in_run = (state_q == ST_RUN);
  assign in_md  = (state_q == ST_STALL_MD);

`ifdef PC_SEQ_CTRL_EXC_EN
  assign exc_v    = exc_req;
  assign eret_v   = eret & in_run;
  assign in_flush = (state_q == ST_EXC_FLUSH);
`else
  logic unused_exc;
  assign unused_exc = exc_req ^ eret;
  assign exc_v      = 1'b0;
  assign eret_v     = 1'b0;
  assign in_flush   = 1'b0;
`endif

  npc_mux u_npc_mux (
    .exc_i        (exc_v),
    .eret_i       (eret_v),
    .hold_i       (in_md),
    .jmp_i        (jmp & in_run),
    .br_i         (br_taken & in_run),
    .pc_cur_i     (pc_cur),
    .br_target_i  (br_target),
    .jmp_target_i (jmp_target),
    .epc_i        (epc),
    .exc_vec_i    (EXC_VEC),
    .npc_o        (mux_npc)
  );

  // A pending exception overrides every stall and the ERET redirect.
  assign npc        = rst ? mux_npc : RESET_PC;
  assign pc_ena     = rst;
  assign pc_stall   = rst & ~exc_v & ((in_run & ~eret_v & ld_use) | in_md);
  assign id_flush   = rst & ((in_run & ~exc_v & ~eret_v & ld_use) | in_flush);
  assign if_flush   = rst & ((eret_v & ~exc_v) | in_flush);
  assign md_timeout = md_timeout_q;
  assign state      = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      md_cnt_q     <= 6'd0;
      md_timeout_q <= 1'b0;
    end else if (exc_v) begin
      state_q  <= ST_EXC_FLUSH;
      md_cnt_q <= 6'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (md_start && !md_done) begin
            state_q  <= ST_STALL_MD;
            md_cnt_q <= 6'd0;
          end
        end
        ST_STALL_MD: begin
          if (md_done) begin
            state_q <= ST_RUN;
          end else if (md_cnt_q == MD_LIMIT) begin
            state_q      <= ST_RUN;
            md_timeout_q <= 1'b1;
          end else begin
            md_cnt_q <= md_cnt_q + 6'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl -- directed self-checking bench for pc_seq_ctrl.
// Rev 1.0
`default_nettype none

module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        ld_use;
  logic        md_start;
  logic        md_done;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] npc;
  logic        pc_ena;
  logic        pc_stall;
  logic        if_flush;
  logic        id_flush;
  logic        md_timeout;
  logic [1:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  pc_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .ld_use     (ld_use),
    .md_start   (md_start),
    .md_done    (md_done),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .npc        (npc),
    .pc_ena     (pc_ena),
    .pc_stall   (pc_stall),
    .if_flush   (if_flush),
    .id_flush   (id_flush),
    .md_timeout (md_timeout),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after posedge; outputs are checked on the negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0; pc_cur = 32'h0040_0000;
    br_taken = 1'b0; br_target = 32'h0; jmp = 1'b0; jmp_target = 32'h0;
    ld_use = 1'b0; md_start = 1'b0; md_done = 1'b0;
    exc_req = 1'b0; eret = 1'b0; epc = 32'h0;

    // reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_npc", npc, 32'h0040_0000);
      check("rst_pc_ena", 32'(pc_ena), 32'd0);
      check("rst_stall", 32'(pc_stall), 32'd0);
      if (i == 0) cyc();
    end
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("rel_state", 32'(state), 32'd0);
    check("rel_npc", npc, 32'h0040_0004);
    check("rel_pc_ena", 32'(pc_ena), 32'd1);
    check("rel_md_to", 32'(md_timeout), 32'd0);

    // load-use single-cycle stall
    cyc(); pc_cur = 32'h0040_0010; ld_use = 1'b1;
    @(negedge clk);
    check("lu_stall", 32'(pc_stall), 32'd1);
    check("lu_idfl", 32'(id_flush), 32'd1);
    check("lu_ena", 32'(pc_ena), 32'd1);
    check("lu_iffl", 32'(if_flush), 32'd0);
    cyc(); ld_use = 1'b0;
    @(negedge clk);
    check("lu_after_stall", 32'(pc_stall), 32'd0);
    check("lu_after_state", 32'(state), 32'd0);

    // jmp beats branch, neither flushes
    cyc(); br_taken = 1'b1; br_target = 32'h0040_0100; jmp = 1'b1; jmp_target = 32'h0040_0200;
    @(negedge clk);
    check("jmp_npc", npc, 32'h0040_0200);
    check("jmp_iffl", 32'(if_flush), 32'd0);
    cyc(); jmp = 1'b0;
    @(negedge clk);
    check("br_npc", npc, 32'h0040_0100);
    check("br_idfl", 32'(id_flush), 32'd0);
    cyc(); br_taken = 1'b0;

    // sequential wrap-around
    pc_cur = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap_npc", npc, 32'h0000_0000);

    // md_start with md_done in the same cycle: no stall
    cyc(); pc_cur = 32'h0040_0030; md_start = 1'b1; md_done = 1'b1;
    @(negedge clk);
    check("md_fast_stall", 32'(pc_stall), 32'd0);
    cyc(); md_start = 1'b0; md_done = 1'b0;
    @(negedge clk);
    check("md_fast_state", 32'(state), 32'd0);

    // md stall completed on its sixth stalled cycle; branch/ld_use ignored
    cyc(); md_start = 1'b1;
    @(negedge clk);
    check("md_issue_stall", 32'(pc_stall), 32'd0);
    cyc(); md_start = 1'b0; br_taken = 1'b1; ld_use = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      md_done = (k == 5);
      @(negedge clk);
      if (pc_stall && state == 2'd1 && npc == 32'h0040_0030) n++;
      cyc();
    end
    md_done = 1'b0; br_taken = 1'b0; ld_use = 1'b0;
    check("md_stall_cycles", 32'(n), 32'd6);
    @(negedge clk);
    check("md_done_state", 32'(state), 32'd0);
    check("md_done_stall", 32'(pc_stall), 32'd0);
    check("md_done_to", 32'(md_timeout), 32'd0);

    // md timeout after 64 stalled cycles
    cyc(); md_start = 1'b1;
    cyc(); md_start = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (state != 2'd1) break;
      n++;
      cyc();
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_state", 32'(state), 32'd0);
    check("to_flag", 32'(md_timeout), 32'd1);
    cyc();
    @(negedge clk);
    check("to_sticky", 32'(md_timeout), 32'd1);

`ifdef PC_SEQ_CTRL_EXC_EN
    // exception beats a taken branch, then one flush cycle
    cyc(); pc_cur = 32'h0040_0040; exc_req = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0100;
    @(negedge clk);
    check("exc_npc", npc, 32'h0040_0004);
    check("exc_stall", 32'(pc_stall), 32'd0);
    cyc(); exc_req = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    check("exfl_state", 32'(state), 32'd2);
    check("exfl_iffl", 32'(if_flush), 32'd1);
    check("exfl_idfl", 32'(id_flush), 32'd1);
    check("exfl_npc", npc, 32'h0040_0044);
    cyc();
    @(negedge clk);
    check("exfl_done", 32'(state), 32'd0);
    check("exfl_done_iffl", 32'(if_flush), 32'd0);

    // eret redirect
    cyc(); eret = 1'b1; epc = 32'h0040_0020;
    @(negedge clk);
    check("eret_npc", npc, 32'h0040_0020);
    check("eret_iffl", 32'(if_flush), 32'd1);
    cyc(); eret = 1'b0;
    @(negedge clk);
    check("eret_after", 32'(if_flush), 32'd0);

    // exception abandons an md stall
    cyc(); md_start = 1'b1;
    cyc(); md_start = 1'b0; exc_req = 1'b1;
    @(negedge clk);
    check("mdexc_npc", npc, 32'h0040_0004);
    check("mdexc_stall", 32'(pc_stall), 32'd0);
    cyc(); exc_req = 1'b0;
    @(negedge clk);
    check("mdexc_state", 32'(state), 32'd2);
    cyc();
`else
    // exception inputs have no effect in this build
    cyc(); pc_cur = 32'h0040_0040; exc_req = 1'b1; eret = 1'b1; epc = 32'h0040_0020;
    @(negedge clk);
    check("noexc_npc", npc, 32'h0040_0044);
    check("noexc_iffl", 32'(if_flush), 32'd0);
    cyc(); exc_req = 1'b0; eret = 1'b0;
    @(negedge clk);
    check("noexc_state", 32'(state), 32'd0);
`endif

    // reset in the middle of an md stall
    cyc(); md_start = 1'b1;
    cyc(); md_start = 1'b0;
    @(negedge clk);
    check("mdrst_pre", 32'(state), 32'd1);
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("mdrst_npc", npc, 32'h0040_0000);
    check("mdrst_stall", 32'(pc_stall), 32'd0);
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("mdrst_state", 32'(state), 32'd0);
    check("mdrst_nstall", 32'(pc_stall), 32'd0);
    check("mdrst_to", 32'(md_timeout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 63: maximum number of cycles spent in STALL_MD.
REQ-002 SHALL have parameter EXC_VEC, default 32'h00400004: exception handler entry address.
REQ-003 SHALL have parameter RESET_PC, default 32'h00400000: value presented on npc during reset.
REQ-004 Port `clk`, input, 1 bit: the only clock; all state changes on posedge.
REQ-005 Port `rst`, input, 1 bit: reset; synchronous, active-low.
REQ-006 Port `pc_cur`, input, 32 bits: current PC register output.
REQ-007 Ports `br_taken` (input, 1 bit) and `br_target` (input, 32 bits): branch resolved in ID.
REQ-008 Ports `jmp` (input, 1 bit) and `jmp_target` (input, 32 bits): J/JAL/JR/JALR target.
REQ-009 Port `ld_use`, input, 1 bit: load-use hazard detected in ID.
REQ-010 Ports `md_start` (input, 1 bit) and `md_done` (input, 1 bit): multi-cycle MULT/DIV issue and completion.
REQ-011 Ports `exc_req` (input, 1 bit), `eret` (input, 1 bit) and `epc` (input, 32 bits): CP0 redirect requests.
REQ-012 Port `npc`, output, 32 bits: next PC, to the PC data input.
REQ-013 Port `pc_ena`, output, 1 bit: PC enable.
REQ-014 Port `pc_stall`, output, 1 bit: PC and IF/ID hold.
REQ-015 Port `if_flush`, output, 1 bit: IF/ID flush.
REQ-016 Port `id_flush`, output, 1 bit: ID/EX bubble.
REQ-017 Port `md_timeout`, output, 1 bit: sticky flag set when STALL_MD is left by timeout.
REQ-018 Port `state`, output, 2 bits: FSM state, for debug.

Function
REQ-019 FSM states SHALL be RUN=0, STALL_MD=1, EXC_FLUSH=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-020 In RUN, npc SHALL be selected combinationally with priority exc_req > eret > jmp > br_taken > sequential pc_cur+4, with 32-bit wrap-around.
REQ-021 In RUN, ld_use=1 (with no exc_req/eret) SHALL assert pc_stall=1 and id_flush=1 in the same cycle, with pc_ena=1; there is no state change and the stall lasts 1 cycle per asserted cycle.
REQ-022 In RUN, md_start=1 with md_done=0 SHALL move to STALL_MD on the next edge and clear md_cnt to 0.
REQ-023 In RUN, md_start=1 with md_done=1 in the same cycle SHALL cause no stall.
REQ-024 In STALL_MD, pc_stall SHALL be 1, npc SHALL equal pc_cur, and br_taken/jmp/ld_use SHALL be ignored.
REQ-025 In STALL_MD, md_cnt (6-bit) SHALL increment each cycle.
REQ-026 STALL_MD SHALL return to RUN on the edge after md_done=1.
REQ-027 STALL_MD SHALL also return to RUN on the edge where md_cnt==MD_TIMEOUT, setting md_timeout.
REQ-028 exc_req=1 in any state SHALL drive npc=EXC_VEC with pc_ena=1 and pc_stall=0 that cycle, and move to EXC_FLUSH on the next edge.
REQ-029 An STALL_MD interrupted by exc_req SHALL be abandoned.
REQ-030 In EXC_FLUSH, for exactly 1 cycle, if_flush=1, id_flush=1 and npc=pc_cur+4; the FSM SHALL then go to RUN.
REQ-031 exc_req asserted during EXC_FLUSH SHALL be serviced again, re-entering EXC_FLUSH.
REQ-032 eret=1 in RUN SHALL drive npc=epc and if_flush=1 for 1 cycle, with no state change.
REQ-033 jmp or br_taken taken in RUN SHALL NOT flush; delay-slot semantics are preserved.
REQ-034 pc_ena SHALL be 1 whenever rst=1.

Reset
REQ-035 While rst=0 at a posedge, state SHALL become RUN, md_cnt 0 and md_timeout 0.
REQ-036 While rst=0, outputs SHALL be npc=RESET_PC, pc_ena=0, pc_stall=0, if_flush=0 and id_flush=0.
REQ-037 Reset asserted mid-STALL_MD or mid-EXC_FLUSH SHALL abandon the operation with no residual flush or stall.

Configuration
REQ-038 Macro PC_SEQ_CTRL_EXC_EN SHALL compile in exc_req/eret/epc handling and the EXC_FLUSH state.
REQ-039 Without PC_SEQ_CTRL_EXC_EN, the ports SHALL remain present but be ignored, EXC_FLUSH SHALL be unreachable, and state 2 SHALL be treated as illegal.

Structure
REQ-040 State encodings, EXC_VEC, RESET_PC and the npc-select codes SHALL live in the shared CPU definitions package/include used by the pipeline.
REQ-041 One sub-module, npc_mux (priority next-PC selector), SHALL be instantiated; all other logic stays in pc_seq_ctrl.

Verification
REQ-042 rst=0 for 2 cycles, then 1 -> npc=32'h00400000 and pc_ena=0 during reset; state=RUN and npc=pc_cur+4 after release.
REQ-043 pc_cur=32'h00400010, ld_use=1 for 1 cycle -> pc_stall=1 and id_flush=1 that cycle; next cycle pc_stall=0.
REQ-044 md_start=1, md_done after 5 cycles -> pc_stall=1 for 6 cycles, state 0→1→0, md_timeout=0; with md_done never asserted -> RUN after 64 cycles and md_timeout=1.
REQ-045 exc_req=1 coincident with br_taken=1 and br_target=32'h00400100 -> npc=32'h00400004; next cycle if_flush=id_flush=1; then RUN.
REQ-046 eret=1 with epc=32'h00400020 -> npc=32'h00400020 and if_flush=1 for 1 cycle.
REQ-047 pc_cur=32'hFFFFFFFC in RUN with no redirect -> npc=32'h00000000.
